// File: rtl/online_test1_pkg.sv
// Shared constants, FSM state and mode encodings, accumulator record and result mux.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package online_test1_pkg;

    localparam int DW      = 4;
    localparam int OW      = 11;
    localparam int MAX_LEN = 8;

    // Accumulator widths, each sized to its worst case for an 8-sample frame.
    localparam int CNT_W   = 4;   // 0..8
    localparam int USUM_W  = 7;   // 0..120
    localparam int SSUM_W  = 8;   // -64..56 in two's complement
    localparam int SQ_W    = 8;   // 0..225 for a single square
    localparam int SQSUM_W = 11;  // 0..1800

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IN   = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_USUM  = 2'd0,
        MODE_SSUM  = 2'd1,
        MODE_SQSUM = 2'd2,
        MODE_RANGE = 2'd3
    } mode_t;

    // Running statistics of the current frame. ssum holds raw two's complement bits.
    typedef struct packed {
        logic [CNT_W-1:0]   count;
        logic [USUM_W-1:0]  usum;
        logic [SSUM_W-1:0]  ssum;
        logic [SQSUM_W-1:0] sqsum;
        logic [DW-1:0]      maxv;
        logic [DW-1:0]      minv;
    } acc_t;

    // Select the statistic for the latched mode and extend it to the output width.
    function automatic logic [OW-1:0] frame_result(input mode_t m, input acc_t a);
        logic [OW-1:0] r;
        logic [DW-1:0] span;
        logic [7:0]    prod;
        span = a.maxv - a.minv;
        prod = {4'b0000, span} * {4'b0000, a.count};
        case (m)
            MODE_USUM:  r = {{(OW-USUM_W){1'b0}}, a.usum};
            MODE_SSUM:  r = {{(OW-SSUM_W){a.ssum[SSUM_W-1]}}, a.ssum};
            MODE_SQSUM: r = a.sqsum;
            MODE_RANGE: r = {{(OW-8){1'b0}}, prod};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/online_test1_if.sv
// Frame input / result output bundle between the stimulus side and the reduction unit.
// Latency: n/a (wiring only).
// Backpressure: none; input is valid-only and the result is a one-cycle strobe.
interface online_test1_if;
    import online_test1_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in;
    logic [1:0]    mode;
    logic          out_valid;
    logic [OW-1:0] out;

    // Stimulus side drives the frame and observes the result.
    modport master (
        output in_valid,
        output in,
        output mode,
        input  out_valid,
        input  out
    );

    // Reduction unit consumes the frame and drives the result.
    modport slave (
        input  in_valid,
        input  in,
        input  mode,
        output out_valid,
        output out
    );

endinterface

// File: rtl/online_test1_acc.sv
// Per-sample update of count, unsigned/signed sums, sum of squares, max and min.
// Latency: one cycle per sample (registered update on the sampling edge).
// Backpressure: none; samples past MAX_LEN are dropped and count saturates.
module online_test1_acc
    import online_test1_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,   // active-high synchronous reset
    input  logic          load,    // first sample of a frame: overwrite everything
    input  logic          accum,   // subsequent sample: fold into running values
    input  logic [DW-1:0] din,
    output acc_t          acc
);

    logic [SQ_W-1:0]   sq;
    logic [SSUM_W-1:0] sx;
    logic [USUM_W-1:0] ux;
    logic              sat;

    assign sq  = {4'b0000, din} * {4'b0000, din};
    assign sx  = {{(SSUM_W-DW){din[DW-1]}}, din};
    assign ux  = {{(USUM_W-DW){1'b0}}, din};
    assign sat = (acc.count >= MAX_CNT);

    // Start a fresh record on load, otherwise fold the sample in until the count saturates.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc.count <= CNT_W'(1);
            acc.usum  <= ux;
            acc.ssum  <= sx;
            acc.sqsum <= {{(SQSUM_W-SQ_W){1'b0}}, sq};
            acc.maxv  <= din;
            acc.minv  <= din;
        end else if (accum && !sat) begin
            acc.count <= acc.count + CNT_W'(1);
            acc.usum  <= acc.usum + ux;
            acc.ssum  <= acc.ssum + sx;
            acc.sqsum <= acc.sqsum + {{(SQSUM_W-SQ_W){1'b0}}, sq};
            if (din > acc.maxv) acc.maxv <= din;
            if (din < acc.minv) acc.minv <= din;
        end
    end

endmodule

// File: rtl/online_test1.sv
// Streaming 4-bit reduction: one mode-selected statistic per frame of 1..8 nibbles.
// Latency: result strobe two edges after the edge that sampled the last nibble.
// Backpressure: none; in_valid while the result is pending is ignored.
module online_test1
    import online_test1_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,   // active-high synchronous reset despite the name
    online_test1_if.slave bus
);

    state_t state;
    state_t state_nxt;
    mode_t  mode_q;
    acc_t   acc;
    logic   load;
    logic   accum;

    logic          out_valid_q;
    logic [OW-1:0] out_q;

    online_test1_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .accum (accum),
        .din   (bus.in),
        .acc   (acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // Frame sequencing: first sample loads, following samples accumulate, drop of in_valid closes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accum     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = IN;
                end
            end
            IN: begin
                if (bus.in_valid) accum     = 1'b1;
                else              state_nxt = OUT;
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Mode is captured only with the first sample so mid-frame changes have no effect.
    always_ff @(posedge clk) begin
        if (rst_n)     mode_q <= MODE_USUM;
        else if (load) mode_q <= mode_t'(bus.mode);
    end

    // Registered result strobe; out is forced to zero whenever no result is presented.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (state == OUT) begin
            out_valid_q <= 1'b1;
            out_q       <= frame_result(mode_q, acc);
        end else begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_online_test1.sv
// Randomised and directed frames against a behavioural model, checked by a queue-based monitor.
// Latency: expected strobe two edges after the last sampled nibble.
// Backpressure: none.
module tb_online_test1;
    import online_test1_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    online_test1_if bus ();

    online_test1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] val;
        int            due;
        string         name;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    // Reference: statistic over the first 8 samples, written from the arithmetic definition.
    function automatic logic [OW-1:0] model(input int m, input int s[$]);
        int n;
        int total;
        int mx;
        int mn;
        logic [31:0] t;
        n     = (s.size() > MAX_LEN) ? MAX_LEN : s.size();
        total = 0;
        mx    = 0;
        mn    = 15;
        for (int i = 0; i < n; i++) begin
            case (m)
                0: total += s[i];
                1: total += (s[i] >= 8) ? s[i] - 16 : s[i];
                2: total += s[i] * s[i];
                default: begin
                    if (s[i] > mx) mx = s[i];
                    if (s[i] < mn) mn = s[i];
                end
            endcase
        end
        if (m == 3) total = (mx - mn) * n;
        t = total;
        return t[OW-1:0];
    endfunction

    // Drive one frame; mode only meaningful on the first cycle, optionally scrambled afterwards.
    task automatic send_frame(input int m, input int s[$], input string name, input bit scramble);
        int gap;
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in       = 4'(s[i]);
            bus.mode     = (i == 0 || !scramble) ? 2'(m) : 2'($urandom);
            if (i == s.size() - 1)
                expq.push_back('{model(m, s), cyc + 3, name});
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in       = 4'($urandom);
        bus.mode     = 2'($urandom);
        gap = 2 + $urandom_range(0, 2);
        repeat (gap) @(posedge clk);
    endtask

    // Frame aborted by reset coinciding with its third sample; no result may appear.
    task automatic reset_frame();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in       = 4'(i + 5);
            bus.mode     = 2'd0;
            if (i == 2) rst_n = 1'b1;
        end
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Monitor: pop on every strobe, require zero output otherwise, flag overdue results.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out_valid", 32'(bus.out), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk({e.name, "_value"}, 32'(bus.out), 32'(e.val));
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("idle_out_zero", 32'(bus.out), 32'd0);
            end
            if (expq.size() > 0 && expq[0].due < cyc) begin
                exp_t e;
                e = expq.pop_front();
                chk({e.name, "_missing_strobe"}, 32'(e.due), 32'(cyc));
            end
        end
    end

    initial begin
        int s[$];
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.mode     = '0;
        rst_n        = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out", 32'(bus.out), 32'd0);
        rst_n = 1'b0;
        repeat (4) @(posedge clk);

        s = '{1, 2, 3, 4};                 send_frame(0, s, "usum_1234", 1'b0);
        s = '{15, 15, 8};                  send_frame(1, s, "ssum_neg10", 1'b0);
        s = '{15, 15, 15, 15, 15, 15, 15, 15};
                                           send_frame(2, s, "sqsum_8x15", 1'b0);
        s = '{15};                         send_frame(2, s, "sqsum_1x15", 1'b0);
        s = '{3, 9, 1};                    send_frame(3, s, "range_391", 1'b0);
        s = '{5};                          send_frame(3, s, "range_single", 1'b0);
        s = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
                                           send_frame(0, s, "usum_sat10", 1'b0);
        s = '{8, 0, 7, 1, 15};             send_frame(1, s, "ssum_modechg", 1'b1);
        reset_frame();
        s = '{2, 7};                       send_frame(0, s, "after_reset", 1'b0);

        for (int f = 0; f < 40; f++) begin
            int len;
            s.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) s.push_back($urandom_range(0, 15));
            send_frame($urandom_range(0, 3), s, "random", 1'b1);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/online_test1.md
Name: online_test1

Overview:
- Streaming 4-bit reduction unit. It accepts a frame of 1..8 input nibbles under `in_valid` and computes one of four mode-selected statistics.
- The 11-bit result is emitted for exactly one cycle with `out_valid`.
- It is a standalone leaf block driven by the PATTERN stimulus/checker in the online-test bench.

Parameters:
- DW, 4: input data width.
- OW, 11: output width.
- MAX_LEN, 8: maximum number of inputs accumulated per frame.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-high reset. The port name is kept for codebase compatibility; reset is in effect when the signal is 1.
- in_valid  input  1  high for consecutive cycles carrying one frame.
- in  input  4  data nibble, valid while in_valid=1.
- mode  input  2  operation select; sampled only on the first in_valid cycle of a frame.
- out_valid  output  1  one-cycle result strobe.
- out  output  11  result; must be 0 whenever out_valid=0.

Behaviour:
- Reset:
  - On a rising edge with rst_n=1: state=IDLE; out_valid=0; out=0; count, sum, sum-of-squares, max and min registers cleared.
  - Reset mid-frame aborts the frame; no result is produced.
- FSM: IDLE -> IN -> OUT -> IDLE.
  - IDLE: when in_valid=1, latch mode, take the first sample, count=1, go to IN.
  - IN: each cycle with in_valid=1, accumulate the sample. When in_valid=0, go to OUT.
  - OUT: out_valid=1 and out=result for exactly one cycle, then IDLE.
- Latency: out_valid rises on the first rising edge after the edge that sampled in_valid=0 following the last sample (no combinational path from inputs to outputs).
- Frame length and spacing:
  - Only the first 8 samples are accumulated; samples 9+ are ignored and count saturates at 8.
  - The frame still ends when in_valid falls.
  - A new frame may start (in_valid=1) the cycle after out_valid drops.
  - in_valid=1 while in OUT is ignored.
- Modes, with N = number of accumulated samples:
  - 0: unsigned sum of in. Maximum 120.
  - 1: signed sum, each in treated as 4-bit two's complement (-8..7). Result is sign-extended to 11-bit two's complement; range -64..56.
  - 2: unsigned sum of squares. Maximum 8*225 = 1800 < 2047.
  - 3: (max - min) * N, all unsigned. Maximum 120; a single sample gives 0.
- Arithmetic:
  - All accumulators are sized to fit their maximum without overflow.
  - out is zero-extended for modes 0, 2 and 3, and sign-extended for mode 1.
- mode changes after the first cycle of a frame are ignored.

Decomposition:
- Shared package online_test1_pkg holds:
  - DW/OW/MAX_LEN constants;
  - the FSM state enum {IDLE, IN, OUT};
  - mode encodings MODE_USUM=0, MODE_SSUM=1, MODE_SQSUM=2, MODE_RANGE=3.
- One natural sub-module, online_test1_acc: per-sample update of count/sums/max/min.
- The top level holds the FSM, mode latch and result mux.

Test Plan:
- Reset held 2 cycles, then idle -> out_valid=0 and out=0 on every cycle.
- mode=0, in = 1, 2, 3, 4 (4 cycles) -> one cycle later out_valid=1 and out=10 for exactly one cycle; out returns to 0 afterwards.
- mode=1, in = 0xF, 0xF, 0x8 -> out = -10, i.e. 11'h7F6 (2038).
- mode=2, eight samples of 15 -> out = 1800. Then back-to-back mode=2 with single sample 15 -> out = 225.
- mode=3, in = 3, 9, 1 -> out = (9-1)*3 = 24. mode=3 with single sample 5 -> out = 0.
- Boundary and reset:
  - mode=0, ten samples of 1 -> out = 8 (saturated count).
  - rst_n=1 asserted during the 3rd sample of a frame -> no out_valid for that frame; the next frame computes correctly.
